// File: rtl/alu_add_arb.sv
// -----------------------------------------------------------------------------
// alu_add_arb
//
// Two-requester adder that time-shares a single 8-bit adder stage. A
// round-robin arbiter grants one requester while idle. The accepted operands
// are then summed one byte per clock, least-significant byte first, and the
// result is presented for one cycle on rsp_valid.
//
// Parameters
//   BYTES          operand width in bytes (1..4); W = 8*BYTES
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   reqN_valid     requester N presents an add operation
//   reqN_ready     requester N is accepted this cycle (idle and granted only)
//   reqN_a/b       W-bit addends of requester N
//   reqN_cin       carry-in of requester N
//   rsp_valid      one-cycle result strobe, no backpressure
//   rsp_id         requester that owns the result
//   rsp_sum        low W bits of a + b + cin
//   rsp_cout       carry out of bit W-1
//   rsp_ovf        signed overflow of the sum
//
// Build option
//   ALU_ARB_OVF_EN defined   : rsp_ovf reports signed overflow
//   ALU_ARB_OVF_EN undefined : rsp_ovf is tied to 0 and no overflow logic exists
// -----------------------------------------------------------------------------
module alu_add_arb #(
  parameter int BYTES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [8*BYTES-1:0] req0_a,
  input  logic [8*BYTES-1:0] req0_b,
  input  logic               req0_cin,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [8*BYTES-1:0] req1_a,
  input  logic [8*BYTES-1:0] req1_b,
  input  logic               req1_cin,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [8*BYTES-1:0] rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_ovf
);

  localparam int         W        = 8 * BYTES;
  localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           carry_q, carry_d;     // running carry, seeded with cin
  logic           id_q, id_d;           // owner of the operation in flight
  logic           last_q, last_d;       // requester granted most recently
  logic [1:0]     idx_q, idx_d;         // byte currently being added
  logic [W-1:0]   acc_q, acc_d;         // partial sum collected so far
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic           rsp_id_q, rsp_id_d;

  // Round-robin grant: a lone requester always wins; on contention the one
  // not granted last wins.
  logic grant0, grant1, fire0, fire1;
  assign grant0     = req0_valid & (~req1_valid | last_q);
  assign grant1     = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign fire0      = req0_valid & req0_ready;
  assign fire1      = req1_valid & req1_ready;

  // Shared 8-bit adder stage operating on byte idx_q.
  logic [4:0]   byte_sh;
  logic [7:0]   byte_a, byte_b;
  logic [8:0]   add9;
  logic [W-1:0] acc_merged;

  assign byte_sh    = {idx_q, 3'b000};
  assign byte_a     = 8'(a_q >> byte_sh);
  assign byte_b     = 8'(b_q >> byte_sh);
  assign add9       = {1'b0, byte_a} + {1'b0, byte_b} + {8'd0, carry_q};
  assign acc_merged = (acc_q & ~(W'(8'hFF) << byte_sh)) | (W'(add9[7:0]) << byte_sh);

`ifdef ALU_ARB_OVF_EN
  logic rsp_ovf_q, rsp_ovf_d;
`endif

  always_comb begin
    // NOTE: every variable gets a hold default first so no path through the
    // case statement leaves it unassigned and infers a latch.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    id_d       = id_q;
    last_d     = last_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_id_d   = rsp_id_q;
`ifdef ALU_ARB_OVF_EN
    rsp_ovf_d  = rsp_ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (fire0 | fire1) begin
          a_d     = fire1 ? req1_a   : req0_a;
          b_d     = fire1 ? req1_b   : req0_b;
          carry_d = fire1 ? req1_cin : req0_cin;
          id_d    = fire1;
          last_d  = fire1;
          idx_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_merged;
        carry_d = add9[8];
        idx_d   = idx_q + 2'd1;
        if (idx_q == LAST_IDX) begin
          // Result registers only move here, so they hold between strobes.
          state_d    = DONE;
          rsp_sum_d  = acc_merged;
          rsp_cout_d = add9[8];
          rsp_id_d   = id_q;
`ifdef ALU_ARB_OVF_EN
          rsp_ovf_d  = (a_q[W-1] == b_q[W-1]) & (acc_merged[W-1] != a_q[W-1]);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;   // req0 wins the first contention
      idx_q      <= 2'd0;
      acc_q      <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= 1'b0;
`ifdef ALU_ARB_OVF_EN
      rsp_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      id_q       <= id_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_id_q   <= rsp_id_d;
`ifdef ALU_ARB_OVF_EN
      rsp_ovf_q  <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
`ifdef ALU_ARB_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`else
  assign rsp_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_add_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_add_arb
//
// Self-checking bench for alu_add_arb with BYTES = 2. Expected results come
// from plain W+1-bit arithmetic, a signed-range overflow test and a
// round-robin pointer kept in the bench.
// -----------------------------------------------------------------------------
module tb_alu_add_arb;

  localparam int BYTES = 2;
  localparam int W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0] rsp_sum;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  alu_add_arb #(.BYTES(BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision sum and signed-range overflow.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, b, input logic cin);
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic cin);
`ifdef ALU_ARB_OVF_EN
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    return (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
`else
    return 1'b0;
`endif
  endfunction

  task automatic scramble_inputs();
    req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
  endtask

  // Single-requester operation with operand scrambling while busy.
  task automatic run_op(input bit id, input logic [W-1:0] a, b, input logic cin);
    logic [W:0] exp;
    int         lat;
    bit         got;
    exp = ref_sum(a, b, cin);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1;
    check("ready_granted", id ? req1_ready : req0_ready, 1);
    check("ready_other",   id ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    // Inputs churn while the operation is in flight.
    scramble_inputs();
    req0_valid = 1'($urandom);
    req1_valid = 1'($urandom);
    #1;
    check("busy_no_rsp", rsp_valid, 0);
    check("busy_no_ready", req0_ready | req1_ready, 0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) got = 1'b1;
      else check("busy_no_ready", req0_ready | req1_ready, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rsp_seen", got, 1);
    check("rsp_latency", lat, BYTES);
    check("rsp_id", rsp_id, id);
    check("rsp_sum", rsp_sum, exp[W-1:0]);
    check("rsp_cout", rsp_cout, exp[W]);
    check("rsp_ovf", rsp_ovf, ref_ovf(a, b, cin));
    @(posedge clk); #1;
    check("rsp_one_cycle", rsp_valid, 0);
    check("rsp_sum_hold", rsp_sum, exp[W-1:0]);
    check("rsp_id_hold", rsp_id, id);
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] sa, sb;
    logic         sc;
    bit           last_grant, w, got;
    int           n, lat, prev_rsp;

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    #2;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_sum", rsp_sum, 0);
    check("reset_rsp_cout", rsp_cout, 0);
    check("reset_rsp_ovf", rsp_ovf, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_no_ready", req0_ready | req1_ready, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0);
    check("dir_sum_0100", rsp_sum, 16'h0100);
    run_op(1'b1, 16'hFFFC, 16'hFFFC, 1'b0);
    check("dir_sum_fff8", rsp_sum, 16'hFFF8);
    run_op(1'b1, 16'hFFFC, 16'hFFFC, 1'b1);
    check("dir_sum_fff9", rsp_sum, 16'hFFF9);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    check("dir_sum_8000", rsp_sum, 16'h8000);
    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b1);
    run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1);

    // Randomized single-requester operations.
    for (int k = 0; k < 16; k++)
      run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));

    // Reset in BUSY discards the operation.
    run_op(1'b1, 16'h1234, 16'h4321, 1'b1);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'hAAAA; req0_b = 16'h5555; req0_cin = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_busy_valid", rsp_valid, 0);
    check("rst_busy_sum", rsp_sum, 0);
    check("rst_busy_cout", rsp_cout, 0);
    check("rst_busy_id", rsp_id, 0);
    check("rst_busy_ovf", rsp_ovf, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_hold_no_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rst_after_no_rsp", rsp_valid, 0);
    end
    run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0);

    // Both requesters held valid from reset: round-robin alternation.
    @(negedge clk);
    reset = 1'b1;
    scramble_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_grant = 1'b1;
    prev_rsp = 0;
    #1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!(req0_ready | req1_ready) && n < 8) begin
        check("rr_not_both", req0_ready & req1_ready, 0);
        @(posedge clk); #1;
        n++;
      end
      w = ~last_grant;
      check("rr_not_both", req0_ready & req1_ready, 0);
      check("rr_some_ready", req0_ready | req1_ready, 1);
      check("rr_winner", req1_ready, w);
      sa = w ? req1_a : req0_a;
      sb = w ? req1_b : req0_b;
      sc = w ? req1_cin : req0_cin;
      exp = ref_sum(sa, sb, sc);
      @(posedge clk); #1;
      last_grant = w;
      scramble_inputs();
      lat = 0;
      got = 1'b0;
      while (!got && lat < 8) begin
        check("rr_not_both", req0_ready & req1_ready, 0);
        @(posedge clk); #1;
        lat++;
        if (rsp_valid) got = 1'b1;
      end
      check("rr_rsp_seen", got, 1);
      check("rr_latency", lat, BYTES);
      check("rr_rsp_id", rsp_id, w);
      check("rr_rsp_sum", rsp_sum, exp[W-1:0]);
      check("rr_rsp_cout", rsp_cout, exp[W]);
      if (k > 0) check("rr_period", cyc - prev_rsp, BYTES + 2);
      prev_rsp = cyc;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
